// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Multi-channel LED pattern generator. A modulo prescaler
//                divides clk down to an exact TICK_HZ pulse. Each channel
//                independently runs OFF, ON, BLINK (programmable half-period
//                in ticks) or BREATHE (triangle-wave PWM brightness).
//
//  Ports
//    clk         system clock, from the PLL output
//    reset       synchronous, active-high reset (PLL not-locked, synchronised)
//    cfg_we      single-cycle configuration write strobe
//    cfg_ch      target channel index of the write
//    cfg_mode    new mode (0 OFF, 1 ON, 2 BLINK, 3 BREATHE)
//    cfg_period  new period, in ticks (a stored 0 behaves as 1)
//    tick        one-cycle pulse at TICK_HZ
//    led         registered LED drive, 1 = lit
//
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int CLK_HZ       = 24000000,
    parameter int TICK_HZ      = 1000,
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 8,
    parameter int PER_BITS     = 16,
    parameter int RESET_MODE   = 2,
    parameter int RESET_PERIOD = 500,
    localparam int c_CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [c_CH_W-1:0]   cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PER_BITS-1:0] cfg_period,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_DIV       = CLK_HZ / TICK_HZ;
    localparam int                  c_PRE_W     = $clog2(c_DIV);
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(c_DIV - 1);
    localparam logic [PWM_BITS-1:0] c_LEVEL_MAX = '1;
    localparam logic [PER_BITS-1:0] c_RST_PER   = PER_BITS'(RESET_PERIOD);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam mode_t c_RST_MODE = mode_t'(2'(RESET_MODE));

    // ------------------------------------------------------------------------
    // Prescaler, tick pulse and shared PWM counter
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0]  r_presc;
    logic                r_tick;
    logic [PWM_BITS-1:0] r_pwm;
    logic [CHANNELS-1:0] w_led;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_pwm   <= '0;
        end else begin
            // Modulo count: exactly DIV cycles per tick, no trimmed offsets.
            r_presc <= (r_presc == c_PRE_LAST) ? '0 : r_presc + 1'b1;
            r_tick  <= (r_presc == c_PRE_LAST);
            r_pwm   <= r_pwm + 1'b1;
        end
    end

    assign tick = r_tick;
    assign led  = w_led;

    // ------------------------------------------------------------------------
    // Per-channel pattern engines. Each channel consumes the registered tick,
    // so the channel update happens on the edge that closes the tick cycle.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        mode_t               r_mode;
        mode_t               w_mode_nxt;
        logic [PER_BITS-1:0] r_period;
        logic [PER_BITS-1:0] w_period_nxt;
        logic [PER_BITS-1:0] r_phase;
        logic [PER_BITS-1:0] w_phase_nxt;
        logic [PER_BITS-1:0] w_p_last;
        logic [PER_BITS-1:0] w_phase_step;
        logic [PWM_BITS-1:0] r_level;
        logic [PWM_BITS-1:0] w_level_nxt;
        logic                r_dir_down;
        logic                w_dir_nxt;
        logic                r_led;
        logic                w_led_nxt;
        logic                w_sel;
        logic                w_wrap;

        // Indices >= CHANNELS never match any channel, so invalid writes
        // fall through with no side effects.
        assign w_sel        = cfg_we && (cfg_ch == c_CH_W'(gi));

        // Effective period max(period,1): last phase value is P-1.
        assign w_p_last     = (r_period == '0) ? '0 : r_period - 1'b1;
        assign w_wrap       = r_tick && (r_phase == w_p_last);
        assign w_phase_step = w_wrap ? '0 : r_phase + 1'b1;

        always_comb begin
            w_mode_nxt   = r_mode;
            w_period_nxt = r_period;
            w_phase_nxt  = r_phase;
            w_level_nxt  = r_level;
            w_dir_nxt    = r_dir_down;
            w_led_nxt    = r_led;

            if (w_sel) begin
                // A write wins over a coincident tick for this channel.
                w_mode_nxt   = mode_t'(cfg_mode);
                w_period_nxt = cfg_period;
                w_phase_nxt  = '0;
                w_level_nxt  = '0;
                w_dir_nxt    = 1'b0;
                // OFF, BLINK and BREATHE (level 0) all start dark.
                w_led_nxt    = (mode_t'(cfg_mode) == MODE_ON);
            end else begin
                case (r_mode)
                    MODE_OFF: begin
                        w_led_nxt = 1'b0;
                    end
                    MODE_ON: begin
                        w_led_nxt = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (r_tick) begin
                            w_phase_nxt = w_phase_step;
                        end
                        if (w_wrap) begin
                            w_led_nxt = ~r_led;
                        end
                    end
                    MODE_BREATHE: begin
                        w_led_nxt = (r_pwm < r_level);
                        if (r_tick) begin
                            w_phase_nxt = w_phase_step;
                        end
                        // At either end the wrap is spent turning around,
                        // so the extremes are held for one extra wrap.
                        if (w_wrap) begin
                            if (!r_dir_down) begin
                                if (r_level == c_LEVEL_MAX) begin
                                    w_dir_nxt = 1'b1;
                                end else begin
                                    w_level_nxt = r_level + 1'b1;
                                end
                            end else begin
                                if (r_level == '0) begin
                                    w_dir_nxt = 1'b0;
                                end else begin
                                    w_level_nxt = r_level - 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        w_led_nxt = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_mode     <= c_RST_MODE;
                r_period   <= c_RST_PER;
                r_phase    <= '0;
                r_level    <= '0;
                r_dir_down <= 1'b0;
                r_led      <= 1'b0;
            end else begin
                r_mode     <= w_mode_nxt;
                r_period   <= w_period_nxt;
                r_phase    <= w_phase_nxt;
                r_level    <= w_level_nxt;
                r_dir_down <= w_dir_nxt;
                r_led      <= w_led_nxt;
            end
        end

        assign w_led[gi] = r_led;
    end

endmodule
`default_nettype wire
